// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: pc_sel encodings, the
// pending-redirect state type and default reset/exception vectors.
package pc_pkg;

    typedef enum logic [1:0] {
        PC_SEQ = 2'b00,
        PC_BR  = 2'b01,
        PC_J   = 2'b10,
        PC_JR  = 2'b11
    } pc_sel_e;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pc_state_e;

    localparam logic [31:0] PC_RESET_VEC_DFLT = 32'h0000_0000;
    localparam logic [31:0] PC_EXC_VEC_DFLT   = 32'h0000_0180;

endpackage

// File: rtl/pc_incr.sv
// Parametrised combinational PC incrementer; generalises the fixed +4 unit.
module pc_incr #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned STEP   = 4
) (
    input  logic [ADDR_W-1:0] pcin,
    output logic [ADDR_W-1:0] pcout
);

    assign pcout = pcin + ADDR_W'(STEP);

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter register and next-PC selection with stall-deferred redirect.
// Optional misaligned-target trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned STEP      = 4,
    parameter logic [31:0] RESET_VEC = PC_RESET_VEC_DFLT,
    parameter logic [31:0] EXC_VEC   = PC_EXC_VEC_DFLT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic [1:0]        pc_sel,
    input  logic              br_taken,
    input  logic [15:0]       br_offset,
    input  logic [25:0]       jmp_target,
    input  logic [ADDR_W-1:0] jr_addr,
    output logic [ADDR_W-1:0] pcout,
    output logic [ADDR_W-1:0] pcplus,
    output logic              redirect_pending,
    output logic              exc,
    output logic [ADDR_W-1:0] epc
);

    localparam logic [ADDR_W-1:0] RESET_A = ADDR_W'(RESET_VEC);
    // Bits at and above 28 survive a J-type jump; a 28-bit PC keeps none.
    localparam logic [ADDR_W-1:0] JMP_HI_MASK = ~ADDR_W'(28'hFFF_FFFF);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] tgt_q, tgt_d;

    logic [ADDR_W-1:0] br_off;
    logic [ADDR_W-1:0] redir_tgt;
    logic              redirect;
    logic              load_en;
    logic [ADDR_W-1:0] load_tgt;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [ADDR_W-1:0] EXC_A = ADDR_W'(EXC_VEC);
    logic              exc_q, exc_d;
    logic [ADDR_W-1:0] epc_q, epc_d;
`endif

    pc_incr #(
        .ADDR_W (ADDR_W),
        .STEP   (STEP)
    ) u_incr (
        .pcin  (pc_q),
        .pcout (pcplus)
    );

    assign br_off = {{(ADDR_W-18){br_offset[15]}}, br_offset, 2'b00};

    always_comb begin
        redirect  = 1'b0;
        redir_tgt = pcplus;
        case (pc_sel_e'(pc_sel))
            PC_BR: begin
                redirect  = br_taken;
                redir_tgt = pcplus + br_off;
            end
            PC_J: begin
                redirect  = 1'b1;
                redir_tgt = (pcplus & JMP_HI_MASK) | ADDR_W'({jmp_target, 2'b00});
            end
            PC_JR: begin
                redirect  = 1'b1;
                redir_tgt = jr_addr;
            end
            default: begin
                redirect  = 1'b0;
                redir_tgt = pcplus;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        tgt_d    = tgt_q;
        pc_d     = pc_q;
        load_en  = 1'b0;
        load_tgt = redir_tgt;
`ifdef PC_ALIGN_CHECK_EN
        exc_d    = 1'b0;
        epc_d    = epc_q;
`endif
        if (stall) begin
            // Latest redirect seen during a stall overwrites the latched one.
            if (redirect) begin
                state_d = PEND;
                tgt_d   = redir_tgt;
            end
        end else begin
            state_d = IDLE;
            if (redirect) begin
                load_en  = 1'b1;
                load_tgt = redir_tgt;
            end else if (state_q == PEND) begin
                load_en  = 1'b1;
                load_tgt = tgt_q;
            end else begin
                pc_d = pcplus;
            end
        end

        if (load_en) begin
`ifdef PC_ALIGN_CHECK_EN
            if (load_tgt[1:0] != 2'b00) begin
                pc_d  = EXC_A;
                exc_d = 1'b1;
                epc_d = load_tgt;
            end else begin
                pc_d = load_tgt;
            end
`else
            pc_d = load_tgt;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            pc_q    <= RESET_A;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            exc_q <= 1'b0;
            epc_q <= '0;
        end else begin
            exc_q <= exc_d;
            epc_q <= epc_d;
        end
    end

    assign exc = exc_q;
    assign epc = epc_q;
`else
    assign exc = 1'b0;
    assign epc = '0;
`endif

    assign pcout            = pc_q;
    assign redirect_pending = (state_q == PEND);

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized checks of pc_sequencer against a behavioural model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic [1:0]  pc_sel = 2'b00;
    logic        br_taken = 1'b0;
    logic [15:0] br_offset = '0;
    logic [25:0] jmp_target = '0;
    logic [31:0] jr_addr = '0;
    logic [31:0] pcout, pcplus, epc;
    logic        redirect_pending, exc;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    logic [31:0] m_pc = '0;
    logic        m_pend = 1'b0;
    logic [31:0] m_tgt = '0;
    logic        m_exc = 1'b0;
    logic [31:0] m_epc = '0;

    pc_sequencer #(
        .ADDR_W    (32),
        .STEP      (4),
        .RESET_VEC (32'h0000_0000),
        .EXC_VEC   (32'h0000_0180)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .pc_sel           (pc_sel),
        .br_taken         (br_taken),
        .br_offset        (br_offset),
        .jmp_target       (jmp_target),
        .jr_addr          (jr_addr),
        .pcout            (pcout),
        .pcplus           (pcplus),
        .redirect_pending (redirect_pending),
        .exc              (exc),
        .epc              (epc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_load(input logic [31:0] t);
`ifdef PC_ALIGN_CHECK_EN
        if (t % 4 != 0) begin
            m_pc  = 32'h0000_0180;
            m_exc = 1'b1;
            m_epc = t;
        end else begin
            m_pc = t;
        end
`else
        m_pc = t;
`endif
    endtask

    // One clock: drive inputs, advance the model, then check all outputs.
    task automatic step(input logic rst, input logic st, input logic [1:0] sel,
                        input logic bt, input logic [15:0] off,
                        input logic [25:0] jt, input logic [31:0] jra);
        logic        redir;
        logic [31:0] seq, t;
        reset = rst; stall = st; pc_sel = sel; br_taken = bt;
        br_offset = off; jmp_target = jt; jr_addr = jra;

        seq   = m_pc + 32'd4;
        redir = (sel == 2'd1 && bt) || sel == 2'd2 || sel == 2'd3;
        if (sel == 2'd1)      t = seq + 32'($signed(off)) * 32'd4;
        else if (sel == 2'd2) t = {seq[31:28], 28'd0} + 32'(jt) * 32'd4;
        else                  t = jra;

        if (rst) begin
            m_pc = '0; m_pend = 1'b0; m_tgt = '0; m_exc = 1'b0; m_epc = '0;
        end else begin
            m_exc = 1'b0;
            if (st) begin
                if (redir) begin
                    m_pend = 1'b1;
                    m_tgt  = t;
                end
            end else begin
                if (redir)       model_load(t);
                else if (m_pend) model_load(m_tgt);
                else             m_pc = seq;
                m_pend = 1'b0;
            end
        end

        @(posedge clk);
        #1;
        chk("pcout", pcout, m_pc);
        chk("pcplus", pcplus, m_pc + 32'd4);
        chk("pending", 32'(redirect_pending), 32'(m_pend));
        chk("exc", 32'(exc), 32'(m_exc));
        chk("epc", epc, m_epc);
    endtask

    task automatic seq_step();
        step(1'b0, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic jr_to(input logic [31:0] a);
        step(1'b0, 1'b0, 2'd3, 1'b0, 16'h0, 26'h0, a);
    endtask

    initial begin
        // Reset, then free-running sequential steps
        step(1'b1, 1'b0, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        step(1'b1, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h1234);
        chk("reset_pc", pcout, 32'h0);
        repeat (3) seq_step();
        chk("free_pc_C", pcout, 32'h0000_000C);

        // Taken / not-taken branch from 0x100
        jr_to(32'h0000_0100);
        step(1'b0, 1'b0, 2'd1, 1'b1, 16'hFFFE, 26'h0, 32'h0);
        chk("br_taken", pcout, 32'h0000_00FC);
        jr_to(32'h0000_0100);
        step(1'b0, 1'b0, 2'd1, 1'b0, 16'hFFFE, 26'h0, 32'h0);
        chk("br_not_taken", pcout, 32'h0000_0104);

        // J-type and jr
        jr_to(32'h0040_0010);
        step(1'b0, 1'b0, 2'd2, 1'b0, 16'h0, 26'h0000123, 32'h0);
        chk("jump", pcout, 32'h0000_048C);
        jr_to(32'h0000_2000);
        chk("jr", pcout, 32'h0000_2000);

        // Stall with overwritten pending redirect
        jr_to(32'h0000_01F0);
        step(1'b0, 1'b1, 2'd1, 1'b1, 16'h0003, 26'h0, 32'h0);
        step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0300);
        step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("stall_hold", pcout, 32'h0000_01F0);
        seq_step();
        chk("stall_release", pcout, 32'h0000_0300);

        // New redirect on release cycle beats the pending one
        step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0200);
        step(1'b0, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        jr_to(32'h0000_0400);
        chk("release_redirect", pcout, 32'h0000_0400);

        // Reset mid-stall discards the pending redirect
        step(1'b0, 1'b1, 2'd3, 1'b0, 16'h0, 26'h0, 32'h0000_0500);
        step(1'b1, 1'b1, 2'd0, 1'b0, 16'h0, 26'h0, 32'h0);
        chk("mid_stall_reset", pcout, 32'h0);
        seq_step();
        chk("no_stale_redirect", pcout, 32'h0000_0004);

        // Wrap-around
        jr_to(32'hFFFF_FFFC);
        seq_step();
        chk("wrap", pcout, 32'h0);

        // Misaligned jr
        jr_to(32'h0000_2002);
`ifdef PC_ALIGN_CHECK_EN
        chk("misalign_pc", pcout, 32'h0000_0180);
        chk("misalign_exc", 32'(exc), 32'd1);
        chk("misalign_epc", epc, 32'h0000_2002);
`else
        chk("misalign_pc", pcout, 32'h0000_2002);
        chk("misalign_exc", 32'(exc), 32'd0);
`endif
        seq_step();
        chk("exc_one_cycle", 32'(exc), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [31:0] a;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            step($urandom_range(0, 49) == 0,
                 $urandom_range(0, 9) < 3,
                 2'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)),
                 16'($urandom),
                 26'($urandom),
                 a);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
